// File: rtl/radio_rx_pkg.sv
// rtl/radio_rx_pkg.sv - shared types and limits for the radio RX-enable sequencer
package radio_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_WARMUP = 2'd1,
        RX_ON     = 2'd2
    } rx_ch_state_e;

    localparam int MAX_CH = 16;

endpackage

// File: rtl/radio_rx_en_ch.sv
// rtl/radio_rx_en_ch.sv - single-channel RX-enable FSM with warm-up delay and min-on hold
module radio_rx_en_ch
    import radio_rx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             arst_n,
    input  logic             isolate,
    input  logic             req,
    input  logic [CNT_W-1:0] on_dly,
    input  logic [CNT_W-1:0] min_on,
    output logic             rx_en,
    output logic             busy,
    output logic             warm_abort
);

    rx_ch_state_e     state_q;
    rx_ch_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             abort_d;

    // Next-state and counter update; isolate overrides everything including the min-on hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        if (isolate) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (req) begin
                        if (on_dly == '0) begin
                            state_d = RX_ON;
                            cnt_d   = min_on;
                        end else begin
                            state_d = RX_WARMUP;
                            cnt_d   = on_dly;
                        end
                    end
                end
                RX_WARMUP: begin
                    if (!req) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                        abort_d = 1'b1;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        // Exit at 1 so the counter never wraps; <= also guards an unreachable 0.
                        state_d = RX_ON;
                        cnt_d   = min_on;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RX_ON: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!req) begin
                        state_d = RX_IDLE;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and outputs are all flops so rx_en cannot glitch on a state decode.
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            rx_en      <= 1'b0;
            busy       <= 1'b0;
            warm_abort <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_en      <= (state_d == RX_ON);
            busy       <= (state_d != RX_IDLE);
            warm_abort <= abort_d;
        end
    end

endmodule

// File: rtl/radio_rx_en_seq.sv
// rtl/radio_rx_en_seq.sv - multi-channel radio RX-enable sequencer top level
module radio_rx_en_seq
    import radio_rx_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              ck,
    input  logic              arst_n,
    input  logic              isolate,
    input  logic [NUM_CH-1:0] req_synced,
    input  logic [CNT_W-1:0]  on_dly,
    input  logic [CNT_W-1:0]  min_on,
    output logic [NUM_CH-1:0] rx_en,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] warm_abort,
    output logic              any_rx_en
);

    // One independent channel per request bit; only config and isolate are shared.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        radio_rx_en_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .ck        (ck),
            .arst_n    (arst_n),
            .isolate   (isolate),
            .req       (req_synced[g]),
            .on_dly    (on_dly),
            .min_on    (min_on),
            .rx_en     (rx_en[g]),
            .busy      (busy[g]),
            .warm_abort(warm_abort[g])
        );
    end

    // Front-end summary enable, combinational from the registered per-channel enables.
    assign any_rx_en = |rx_en;

endmodule

// File: tb/tb_radio_rx_en_seq.sv
// tb/tb_radio_rx_en_seq.sv - self-checking bench for radio_rx_en_seq
module tb_radio_rx_en_seq;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              ck;
    logic              arst_n;
    logic              isolate;
    logic [NUM_CH-1:0] req_synced;
    logic [CNT_W-1:0]  on_dly;
    logic [CNT_W-1:0]  min_on;
    logic [NUM_CH-1:0] rx_en;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] warm_abort;
    logic              any_rx_en;

    radio_rx_en_seq #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .ck        (ck),
        .arst_n    (arst_n),
        .isolate   (isolate),
        .req_synced(req_synced),
        .on_dly    (on_dly),
        .min_on    (min_on),
        .rx_en     (rx_en),
        .busy      (busy),
        .warm_abort(warm_abort),
        .any_rx_en (any_rx_en)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic              iso;
        logic [NUM_CH-1:0] req;
        logic [CNT_W-1:0]  od;
        logic [CNT_W-1:0]  mo;
        logic [NUM_CH-1:0] rx;
        logic [NUM_CH-1:0] bsy;
        logic [NUM_CH-1:0] ab;
    } vec_t;

    vec_t tbl[$];

    // Reference model: per channel, timestamps of when it turns on and until when it is held.
    int      m_ph[NUM_CH];
    longint  m_turn[NUM_CH];
    longint  m_hold[NUM_CH];
    logic [NUM_CH-1:0] m_ab;
    longint  ecnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " rx_en"}, 32'(rx_en), 32'd0);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " warm_abort"}, 32'(warm_abort), 32'd0);
        chk({name, " any_rx_en"}, 32'(any_rx_en), 32'd0);
    endtask

    task automatic do_reset();
        arst_n     = 1'b0;
        isolate    = 1'b0;
        req_synced = '0;
        step();
        step();
        arst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) m_ph[c] = 0;
        m_ab = '0;
        ecnt = 0;
    endtask

    task automatic model_edge(input logic iso, input logic [NUM_CH-1:0] req, input longint od, input longint mo);
        m_ab = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (iso) begin
                m_ph[c] = 0;
            end else if (m_ph[c] == 0) begin
                if (req[c]) begin
                    if (od == 0) begin
                        m_ph[c] = 2;
                        m_hold[c] = ecnt + mo;
                    end else begin
                        m_ph[c] = 1;
                        m_turn[c] = ecnt + od;
                    end
                end
            end else if (m_ph[c] == 1) begin
                if (!req[c]) begin
                    m_ph[c] = 0;
                    m_ab[c] = 1'b1;
                end else if (ecnt == m_turn[c]) begin
                    m_ph[c] = 2;
                    m_hold[c] = ecnt + mo;
                end
            end else begin
                if (!req[c] && ecnt > m_hold[c]) m_ph[c] = 0;
            end
        end
        ecnt++;
    endtask

    function automatic vec_t mk(logic iso, logic [NUM_CH-1:0] req, int od, int mo,
                                logic [NUM_CH-1:0] rx, logic [NUM_CH-1:0] bsy, logic [NUM_CH-1:0] ab);
        vec_t v;
        v.iso = iso; v.req = req; v.od = CNT_W'(od); v.mo = CNT_W'(mo);
        v.rx = rx; v.bsy = bsy; v.ab = ab;
        return v;
    endfunction

    initial begin
        logic [NUM_CH-1:0] prev_req;
        logic [NUM_CH-1:0] exp_rx;
        logic [NUM_CH-1:0] exp_bsy;

        arst_n     = 1'b0;
        isolate    = 1'b0;
        req_synced = '0;
        on_dly     = '0;
        min_on     = '0;

        // Latency: on_dly=3, min_on=0 on ch0
        tbl.push_back(mk(0, 4'b0001, 3, 0, 4'b0000, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 3, 0, 4'b0000, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 3, 0, 4'b0000, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 3, 0, 4'b0001, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 3, 0, 4'b0000, 4'b0000, 4'b0000));
        // Abort: on_dly=5, ch1 req for 2 cycles
        tbl.push_back(mk(0, 4'b0010, 5, 0, 4'b0000, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 5, 0, 4'b0000, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 5, 0, 4'b0000, 4'b0000, 4'b0010));
        tbl.push_back(mk(0, 4'b0000, 5, 0, 4'b0000, 4'b0000, 4'b0000));
        // Min-on: on_dly=0, min_on=4, ch2 req for 1 cycle -> 5 cycles high
        tbl.push_back(mk(0, 4'b0100, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, 4'b0000));
        // Re-raise during hold: no gap
        tbl.push_back(mk(0, 4'b0100, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, 4'b0000));
        // Isolate: ch3 ON with min_on=10, 7 cycles remaining, then isolate
        tbl.push_back(mk(0, 4'b1000, 0, 10, 4'b1000, 4'b1000, 4'b0000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0000, 0, 10, 4'b1000, 4'b1000, 4'b0000));
        tbl.push_back(mk(1, 4'b1000, 0, 10, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b1000, 0, 10, 4'b0000, 4'b0000, 4'b0000));
        // Release with req high: full warm-up of on_dly=2 -> rx_en after 3 edges
        tbl.push_back(mk(0, 4'b1000, 2, 10, 4'b0000, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 2, 10, 4'b0000, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 2, 10, 4'b1000, 4'b1000, 4'b0000));

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            isolate    = 1'($urandom);
            req_synced = NUM_CH'($urandom);
            on_dly     = CNT_W'($urandom_range(0, 3));
            min_on     = CNT_W'($urandom_range(0, 3));
            step();
            chk_all_zero($sformatf("reset_hold%0d", i));
        end
        isolate    = 1'b0;
        req_synced = '0;
        arst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all_zero($sformatf("reset_release%0d", i));
        end

        // Table-driven directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            isolate    = tbl[i].iso;
            req_synced = tbl[i].req;
            on_dly     = tbl[i].od;
            min_on     = tbl[i].mo;
            step();
            chk($sformatf("vec%0d rx_en", i), 32'(rx_en), 32'(tbl[i].rx));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("vec%0d warm_abort", i), 32'(warm_abort), 32'(tbl[i].ab));
            chk($sformatf("vec%0d any_rx_en", i), 32'(any_rx_en), 32'(|tbl[i].rx));
        end

        // Simultaneous isolate and req rise: isolate wins
        isolate    = 1'b1;
        req_synced = '0;
        step();
        req_synced = 4'b0100;
        on_dly     = '0;
        min_on     = '0;
        step();
        chk_all_zero("iso_vs_req");
        isolate    = 1'b0;
        req_synced = '0;
        step();
        chk_all_zero("iso_release_noreq");

        // Asynchronous reset mid-operation
        req_synced = 4'b1111;
        step();
        chk("pre_arst rx_en", 32'(rx_en), 32'hF);
        #3;
        arst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        #1;
        arst_n = 1'b1;
        req_synced = '0;

        // Degenerate: no delay, no hold -> rx_en is req delayed by one edge
        do_reset();
        on_dly   = '0;
        min_on   = '0;
        prev_req = '0;
        for (int i = 0; i < 60; i++) begin
            req_synced = NUM_CH'($urandom);
            prev_req   = req_synced;
            step();
            chk($sformatf("degen%0d rx_en", i), 32'(rx_en), 32'(prev_req));
            chk($sformatf("degen%0d any", i), 32'(any_rx_en), 32'(|prev_req));
        end

        // Randomized run against the reference model
        do_reset();
        on_dly = CNT_W'(2);
        min_on = CNT_W'(3);
        for (int i = 0; i < 800; i++) begin
            isolate = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 3) == 0) req_synced[c] = ~req_synced[c];
            if ($urandom_range(0, 15) == 0) on_dly = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) min_on = CNT_W'($urandom_range(0, 5));
            model_edge(isolate, req_synced, longint'(on_dly), longint'(min_on));
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                exp_rx[c]  = (m_ph[c] == 2);
                exp_bsy[c] = (m_ph[c] != 0);
            end
            chk($sformatf("rand%0d rx_en", i), 32'(rx_en), 32'(exp_rx));
            chk($sformatf("rand%0d busy", i), 32'(busy), 32'(exp_bsy));
            chk($sformatf("rand%0d warm_abort", i), 32'(warm_abort), 32'(m_ab));
            chk($sformatf("rand%0d any", i), 32'(any_rx_en), 32'(|exp_rx));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
